emu_transactor: RTL and testbench



---
 rtl/emu_transactor_if.sv | 24 ++
 rtl/emu_transactor.sv | 124 ++++++++++++
 tb/tb_emu_transactor.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/emu_transactor_if.sv
// Host-side byte bus of the emulation transactor: write/load/get commands in,
// registered read data and run status out.
interface emu_transactor_if #(
  parameter int ADDR_W = 3
);
  logic [7:0]        Din_emu;
  logic [7:0]        Dout_emu;
  logic [ADDR_W-1:0] Addr_emu;
  logic              we_emu;
  logic              load_emu;
  logic              get_emu;
  logic              busy_emu;
  logic              done_emu;

  modport master (
    output Din_emu, Addr_emu, we_emu, load_emu, get_emu,
    input  Dout_emu, busy_emu, done_emu
  );

  modport slave (
    input  Din_emu, Addr_emu, we_emu, load_emu, get_emu,
    output Dout_emu, busy_emu, done_emu
  );
endinterface

// File: rtl/emu_transactor.sv
// Co-emulation transactor: host-loaded stimulus bytes, N-cycle DUT runs via dut_ce, auto capture.
// Optional EMU_MONITOR_EN adds clk_LED driven by bit 3 of a DUT-cycle counter.
module emu_transactor #(
  parameter int NUM_STIM_BYTES = 4,
  parameter int NUM_OUT_BYTES  = 3,
  parameter int ADDR_W         = 3
) (
  input  logic                        clk_emu,
  input  logic                        rst_emu,
  emu_transactor_if.slave             host,
  output logic [8*NUM_STIM_BYTES-1:0] dut_in,
  input  logic [8*NUM_OUT_BYTES-1:0]  dut_out,
`ifdef EMU_MONITOR_EN
  output logic                        clk_LED,
`endif
  output logic                        dut_ce
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  logic [1:0]                         state_q, state_d;
  logic [7:0]                         cnt_q, cnt_d;
  logic [7:0]                         dout_q, dout_d;
  logic [NUM_STIM_BYTES-1:0][7:0]     stim_q, stim_d;
  logic [NUM_OUT_BYTES-1:0][7:0]      vect_q, vect_d;
  logic [8*NUM_STIM_BYTES-1:0]        dut_in_q, dut_in_d;
  logic [8*NUM_STIM_BYTES-1:0]        stim_flat;
  logic [NUM_OUT_BYTES-1:0][7:0]      cap;

  // Byte k sits at the k-th byte from the MSB end on both DUT buses.
  for (genvar k = 0; k < NUM_STIM_BYTES; k++) begin : g_stim_map
    assign stim_flat[8*(NUM_STIM_BYTES-k)-1 -: 8] = stim_q[k];
  end

  for (genvar k = 0; k < NUM_OUT_BYTES; k++) begin : g_cap_map
    assign cap[k] = dut_out[8*(NUM_OUT_BYTES-k)-1 -: 8];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stim_d   = stim_q;
    vect_d   = vect_q;
    dut_in_d = dut_in_q;
    dout_d   = 8'h00;

    // Host writes land in any state so the next vector can be staged mid-run.
    for (int k = 0; k < NUM_STIM_BYTES; k++) begin
      if (host.we_emu && host.Addr_emu == ADDR_W'(k))
        stim_d[k] = host.Din_emu;
    end

    case (state_q)
      S_IDLE: begin
        if (host.load_emu) begin
          dut_in_d = stim_flat;
          cnt_d    = host.Din_emu;
          state_d  = (host.Din_emu != 8'd0) ? S_RUN : S_CAPT;
        end else if (host.get_emu) begin
          vect_d = cap;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1)
          state_d = S_CAPT;
      end
      S_CAPT: begin
        vect_d  = cap;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < NUM_OUT_BYTES; k++) begin
      if (host.Addr_emu == ADDR_W'(k))
        dout_d = vect_q[k];
    end
  end

  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      stim_q   <= '0;
      vect_q   <= '0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      stim_q   <= stim_d;
      vect_q   <= vect_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign dut_in        = dut_in_q;
  assign dut_ce        = (state_q == S_RUN);
  assign host.busy_emu = (state_q != S_IDLE);
  assign host.done_emu = (state_q == S_CAPT);
  assign host.Dout_emu = dout_q;

`ifdef EMU_MONITOR_EN
  logic [3:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (dut_ce)
      led_d = led_q + 4'd1;
  end

  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) led_q <= '0;
    else         led_q <= led_d;
  end

  assign clk_LED = led_q[3];
`endif

endmodule

// File: tb/tb_emu_transactor.sv
// Bench for emu_transactor: vector table of load runs behind a 3-stage pipelined DUT model,
// plus hand sequences for manual get, busy-time commands, write/load collision and mid-run reset.
module tb_emu_transactor;
  localparam int N  = 4;
  localparam int M  = 3;
  localparam int AW = 3;

  logic           clk_emu = 1'b0;
  logic           rst_emu;
  logic [8*N-1:0] dut_in;
  logic [8*M-1:0] dut_out;
  logic           dut_ce;
`ifdef EMU_MONITOR_EN
  logic           clk_LED;
`endif

  emu_transactor_if #(.ADDR_W(AW)) host();

  emu_transactor #(.NUM_STIM_BYTES(N), .NUM_OUT_BYTES(M), .ADDR_W(AW)) u_dut (
    .clk_emu (clk_emu),
    .rst_emu (rst_emu),
    .host    (host),
    .dut_in  (dut_in),
    .dut_out (dut_out),
`ifdef EMU_MONITOR_EN
    .clk_LED (clk_LED),
`endif
    .dut_ce  (dut_ce)
  );

  always #5 clk_emu = ~clk_emu;

  // Emulated DUT: dut_in delayed by three enabled edges, top M bytes returned,
  // or a directly driven value when bypass is set.
  logic [8*N-1:0] p1, p2, p3;
  logic           bypass;
  logic [8*M-1:0] ext_out;

  always @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      p1 <= '0; p2 <= '0; p3 <= '0;
    end else if (dut_ce) begin
      p1 <= dut_in; p2 <= p1; p3 <= p2;
    end
  end

  assign dut_out = bypass ? ext_out : p3[8*N-1 -: 8*M];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    host.Addr_emu = a;
    host.Din_emu  = d;
    host.we_emu   = 1'b1;
    @(negedge clk_emu);
    host.we_emu   = 1'b0;
  endtask

  // Issue a load at the current negedge and follow the run to done_emu (bounded).
  task automatic run_load(input logic [7:0] n, input bit wr_too, output int ce, output int lat);
    ce  = 0;
    lat = -1;
    host.Din_emu  = n;
    host.load_emu = 1'b1;
    host.we_emu   = wr_too;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk_emu);
      host.load_emu = 1'b0;
      host.we_emu   = 1'b0;
      if (dut_ce) ce++;
      if (host.done_emu) begin
        lat = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    exp;
  } rd_t;

  // Sweep all addresses; expected bytes queue up at address drive, pop one cycle later.
  task automatic read_check(input string nm, input logic [8*M-1:0] v);
    rd_t        tbl[8];
    logic [7:0] sb[$];
    logic [7:0] e;
    for (int k = 0; k < 8; k++) begin
      tbl[k].addr = AW'(k);
      tbl[k].exp  = 8'h00;
      if (k < M) tbl[k].exp = v[8*(M-k)-1 -: 8];
    end
    host.Addr_emu = tbl[0].addr;
    sb.push_back(tbl[0].exp);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_emu);
      e = sb.pop_front();
      check($sformatf("%s rd[%0d]", nm, k-1), {24'd0, host.Dout_emu}, {24'd0, e});
      if (k < 8) begin
        host.Addr_emu = tbl[k].addr;
        sb.push_back(tbl[k].exp);
      end
    end
  endtask

  typedef struct {
    logic [31:0]    stim;
    logic [7:0]     cnt;
    bit             byp;
    logic [8*M-1:0] ext;
    int             ce;
    int             lat;
    logic [8*M-1:0] vect;
  } vec_t;

`ifdef EMU_MONITOR_EN
  int led_m = 0;
  always @(negedge clk_emu) begin
    if (rst_emu) led_m = 0;
    else begin
      check("clk_LED", {31'd0, clk_LED}, {31'd0, led_m[3]});
      if (dut_ce) led_m = (led_m + 1) % 16;
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   ce, lat;

    tbl[0] = '{32'h11223344, 8'd1,   1'b1, 24'hCAFE01, 1,   2,   24'hCAFE01};
    tbl[1] = '{32'hA1B2C3D4, 8'd3,   1'b0, 24'h000000, 3,   4,   24'hA1B2C3};
    tbl[2] = '{32'h0F1E2D3C, 8'd0,   1'b1, 24'h010203, 0,   1,   24'h010203};
    tbl[3] = '{32'h55667788, 8'd7,   1'b0, 24'h000000, 7,   8,   24'h556677};
    tbl[4] = '{32'h99AABBCC, 8'd255, 1'b0, 24'h000000, 255, 256, 24'h99AABB};

    host.Din_emu  = '0;
    host.Addr_emu = '0;
    host.we_emu   = 1'b0;
    host.load_emu = 1'b0;
    host.get_emu  = 1'b0;
    bypass        = 1'b1;
    ext_out       = '0;
    rst_emu       = 1'b1;

    #12;
    check("reset dut_in", dut_in, 32'h0);
    check("reset dut_ce", {31'd0, dut_ce}, 32'd0);
    check("reset busy",   {31'd0, host.busy_emu}, 32'd0);
    check("reset done",   {31'd0, host.done_emu}, 32'd0);
    check("reset Dout",   {24'd0, host.Dout_emu}, 32'd0);
    @(negedge clk_emu);
    rst_emu = 1'b0;
    @(negedge clk_emu);

    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < N; b++) wr(AW'(b), tbl[i].stim[31-8*b -: 8]);
      bypass  = tbl[i].byp;
      ext_out = tbl[i].ext;
      run_load(tbl[i].cnt, 1'b0, ce, lat);
      check($sformatf("v%0d dut_in", i), dut_in, tbl[i].stim);
      check($sformatf("v%0d ce count", i), ce, tbl[i].ce);
      check($sformatf("v%0d done latency", i), lat, tbl[i].lat);
      @(negedge clk_emu);
      check($sformatf("v%0d done one-shot", i), {31'd0, host.done_emu}, 32'd0);
      check($sformatf("v%0d idle busy", i), {31'd0, host.busy_emu}, 32'd0);
      read_check($sformatf("v%0d", i), tbl[i].vect);
    end

    // Manual capture from IDLE: no run, no done pulse.
    bypass  = 1'b1;
    ext_out = 24'h5A6B7C;
    host.get_emu = 1'b1;
    @(negedge clk_emu);
    host.get_emu = 1'b0;
    check("get done", {31'd0, host.done_emu}, 32'd0);
    check("get busy", {31'd0, host.busy_emu}, 32'd0);
    check("get ce",   {31'd0, dut_ce}, 32'd0);
    read_check("get", 24'h5A6B7C);

    // Commands while busy: load/get ignored, write to stimIn accepted.
    host.Addr_emu = '0;
    ext_out = 24'h123456;
    @(negedge clk_emu);
    host.Din_emu  = 8'd5;
    host.load_emu = 1'b1;
    ce = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_emu);
      if (i == 1) begin
        host.get_emu = 1'b1; host.we_emu = 1'b1; host.Din_emu = 8'hAA;
        ext_out = 24'hFFFFFF;
      end else if (i == 2) begin
        host.load_emu = 1'b0; host.get_emu = 1'b0; host.we_emu = 1'b0;
        ext_out = 24'h123456;
      end
      if (dut_ce) ce++;
      check($sformatf("busy dut_in hold c%0d", i), dut_in, 32'h99AABBCC);
      if (i == 3) check("busy get ignored", {24'd0, host.Dout_emu}, 32'h5A);
      if (host.done_emu) begin
        lat = i;
        break;
      end
    end
    check("busy ce count", ce, 5);
    check("busy done latency", lat, 6);
    @(negedge clk_emu);

    // Out-of-range write must not alias onto a stimulus byte.
    wr(AW'(4), 8'hEE);
    run_load(8'd0, 1'b0, ce, lat);
    check("preload dut_in", dut_in, 32'hAAAABBCC);
    check("preload ce", ce, 0);
    check("preload latency", lat, 1);
    @(negedge clk_emu);
    read_check("preload", 24'h123456);

    // Write and load together on byte 1: dut_in sees the old byte.
    host.Addr_emu = AW'(1);
    run_load(8'd2, 1'b1, ce, lat);
    check("collide dut_in", dut_in, 32'hAAAABBCC);
    check("collide ce", ce, 2);
    check("collide latency", lat, 3);
    @(negedge clk_emu);
    run_load(8'd0, 1'b0, ce, lat);
    check("collide next dut_in", dut_in, 32'hAA02BBCC);
    @(negedge clk_emu);

    // Reset in the middle of a 10-cycle run.
    ext_out = 24'h314159;
    host.Din_emu  = 8'd10;
    host.load_emu = 1'b1;
    ce = 0;
    for (int i = 0; i < 20 && ce < 3; i++) begin
      @(negedge clk_emu);
      host.load_emu = 1'b0;
      if (dut_ce) ce++;
    end
    check("rst pre ce", ce, 3);
    #2 rst_emu = 1'b1;
    #1;
    check("rst dut_ce", {31'd0, dut_ce}, 32'd0);
    check("rst busy",   {31'd0, host.busy_emu}, 32'd0);
    check("rst done",   {31'd0, host.done_emu}, 32'd0);
    check("rst dut_in", dut_in, 32'h0);
    check("rst Dout",   {24'd0, host.Dout_emu}, 32'd0);
    @(negedge clk_emu);
    rst_emu = 1'b0;
    read_check("rst vect", 24'h000000);
    run_load(8'd0, 1'b0, ce, lat);
    check("rst stim cleared", dut_in, 32'h0);
    check("rst idle reload latency", lat, 1);
    @(negedge clk_emu);
    read_check("rst capture", 24'h314159);

`ifdef EMU_MONITOR_EN
    run_load(8'd16, 1'b0, ce, lat);
    check("led run ce", ce, 16);
    @(negedge clk_emu);
    check("led after 16", {31'd0, clk_LED}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
